usr_seq: RTL
============

# usr_seq

Parametrised, sequential universal shift register; successor to the team's fixed 8-bit shift/rotate register. Generalised to WIDTH bits and multi-bit shift amounts executed one bit per clock under a start/busy/done handshake. Adds serial fill input, arithmetic shift right and a captured shift-out bit. Sits between the datapath load bus and downstream consumers that poll `done`.

## Interface
- WIDTH, 8, register width in bits; must be ≥ 2.
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount field; must cover amounts 0..WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst_a  input  1  reset, asynchronous, active-high.
- load  input  1  when idle, capture `din` into `q`.
- din  input  WIDTH  parallel load data.
- start  input  1  when idle and `load`=0, begin an operation.
- mode  input  3  operation select, sampled with `start`.
- amt  input  AMT_W  number of single-bit steps, sampled with `start`.
- ser_in  input  1  fill bit for logical shifts, sampled on every step.
- q  output  WIDTH  register contents.
- shout  output  1  last bit shifted or rotated out of `q`.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.

## Operation
- Reset values: `q`=0, `shout`=0, `busy`=0, `done`=0, internal step counter=0, state IDLE.
- States:
  - IDLE → RUN on `start` with `amt`≠0.
  - IDLE → IDLE with `done` pulse on `start` with `amt`=0.
  - RUN → IDLE with `done` pulse when the counter reaches 0 after a step.
- Priority in IDLE: `load` over `start`.
  - `load`=1 sets `q`←`din` and leaves `shout` unchanged; `start` is ignored that cycle; no `done` pulse.
- In RUN, `load`, `start`, `mode` and `amt` are ignored. `mode` and `amt` are latched at start and apply for the whole operation.
- Per-step function (`q` before step = Q, W = WIDTH):
  - 000 LSL: q←{Q[W-2:0], ser_in}; shout←Q[W-1].
  - 001 LSR: q←{ser_in, Q[W-1:1]}; shout←Q[0].
  - 010 ROL: q←{Q[W-2:0], Q[W-1]}; shout←Q[W-1].
  - 011 ROR: q←{Q[0], Q[W-1:1]}; shout←Q[0].
  - 100 ASR: q←{Q[W-1], Q[W-1:1]}; shout←Q[0].
  - 101–111: reserved. Runs as a normal timed operation with `q` and `shout` held; `busy`/`done` behave as for any mode.
- `amt` larger than WIDTH is legal; steps are executed literally and rotates wrap naturally.
- `done` is high for exactly one cycle per accepted `start`, never during `busy`.

## Timing
- Edge E0 samples `start`=1 in IDLE with `amt`=N>0:
  - After E0: `busy`=1, counter=N, `q` unchanged.
  - Edges E1..EN each perform one step and decrement the counter.
  - After EN: `busy`=0, `done`=1.
  - After EN+1: `done`=0.
  - Total latency N+1 cycles from the start edge to `done`.
- `amt`=0: after E0 `done`=1, `busy` stays 0, `q`/`shout` unchanged.
- Back-to-back: `start` may be asserted in the cycle `done` is high; it is accepted at that edge (IDLE).
- `ser_in` is sampled at each step edge E1..EN, not at E0.
- Reset asserted mid-operation: immediate return to reset values, no `done`. After deassertion the block is idle and waits for a new `start`.
- `load` and `start` both high in IDLE: load wins; the start is dropped and must be reissued.

## Test plan
- Reset then load: assert `rst_a` → `q`=0, `busy`=0, `done`=0; `load` with `din`=8'hA5 → `q`=8'hA5 next edge, no `done`.
- LSL by 3: `q`=8'hA5, `ser_in`=1, mode 000, `amt`=3 → `busy` for 3 step edges, final `q`=8'h2F, `shout`=1, `done` pulse 4 cycles after start.
- ASR and ROR: `q`=8'h90, mode 100, `amt`=2 → `q`=8'hE4, `shout`=0. Then mode 011, `amt`=9 → `q`=8'h72, `shout`=0, done after 10 cycles.
- Zero amount and reserved mode: `amt`=0 → `done` the next cycle, `busy` never high. Mode 110, `amt`=4 → `q` unchanged, `done` after 5 cycles.
- Ignore during busy and priority: during a 5-step ROL, pulse `load` (`din`=8'hFF) and `start` → no effect on `q`. In IDLE, `load`+`start` together → `q`=`din`, no `busy`, no `done`.
- Reset mid-operation: assert `rst_a` at step 2 of a 6-step LSR → `q`=0, `busy`=0, no `done`. A fresh start after deassertion completes normally.

Source files
------------

// File: rtl/usr_seq_if.sv
// usr_seq load/control/status bundle.
// master drives controls; slave is the shifter.
interface usr_seq_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             start;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amt;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             shout;
  logic             busy;
  logic             done;

  modport master (
    output load, din, start, mode, amt, ser_in,
    input  q, shout, busy, done
  );

  modport slave (
    input  load, din, start, mode, amt, ser_in,
    output q, shout, busy, done
  );
endinterface

// File: rtl/usr_seq.sv
// Universal shift register, one bit per clock.
// start/busy/done handshake, latched mode/amount.
module usr_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic      clk,
  input  logic      rst_a,
  usr_seq_if.slave  bus
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  localparam logic [2:0] M_LSL = 3'b000;
  localparam logic [2:0] M_LSR = 3'b001;
  localparam logic [2:0] M_ROL = 3'b010;
  localparam logic [2:0] M_ROR = 3'b011;
  localparam logic [2:0] M_ASR = 3'b100;

  state_e           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             shout_q, shout_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_q;
  logic             step_sh;

  // Reserved modes fall through and hold q/shout.
  always_comb begin
    step_q  = q_q;
    step_sh = shout_q;
    case (mode_q)
      M_LSL: begin
        step_q  = {q_q[WIDTH-2:0], bus.ser_in};
        step_sh = q_q[WIDTH-1];
      end
      M_LSR: begin
        step_q  = {bus.ser_in, q_q[WIDTH-1:1]};
        step_sh = q_q[0];
      end
      M_ROL: begin
        step_q  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        step_sh = q_q[WIDTH-1];
      end
      M_ROR: begin
        step_q  = {q_q[0], q_q[WIDTH-1:1]};
        step_sh = q_q[0];
      end
      M_ASR: begin
        step_q  = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        step_sh = q_q[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    q_d     = q_q;
    shout_d = shout_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          q_d = bus.din;
        end else if (bus.start) begin
          mode_d = bus.mode;
          cnt_d  = bus.amt;
          if (bus.amt == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        q_d     = step_q;
        shout_d = step_sh;
        cnt_d   = cnt_q - AMT_W'(1);
        // Last step: done rises as busy falls.
        if (cnt_q == AMT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      q_q     <= '0;
      shout_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
      shout_q <= shout_d;
      done_q  <= done_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.shout = shout_q;
  assign bus.busy  = (state_q == S_RUN);
  assign bus.done  = done_q;

endmodule
